id_stage: RTL

//  RV32I decode stage and ID/EX pipeline register. Drives the register-file read

---
 rtl/id_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// RV32I decode stage and ID/EX pipeline register: operand fetch with WB->ID bypass,
// immediate and control generation, load-use stall and EX flush handling.
module id_stage #(
    parameter int unsigned     XLEN   = 32,
    parameter logic [XLEN-1:0] NOP_PC = '0
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            IF_VALID,
    input  logic [31:0]     IF_INSTR,
    input  logic [XLEN-1:0] IF_PC,
    output logic [4:0]      RNUM1,
    output logic [4:0]      RNUM2,
    input  logic [XLEN-1:0] RDATA1,
    input  logic [XLEN-1:0] RDATA2,
    input  logic [4:0]      WB_WNUM,
    input  logic [XLEN-1:0] WB_WDATA,
    input  logic            EX_FLUSH,
    output logic            STALL,
    output logic            EX_VALID,
    output logic [XLEN-1:0] EX_PC,
    output logic [XLEN-1:0] EX_RS1VAL,
    output logic [XLEN-1:0] EX_RS2VAL,
    output logic [XLEN-1:0] EX_IMM,
    output logic [4:0]      EX_RS1,
    output logic [4:0]      EX_RS2,
    output logic [4:0]      EX_RD,
    output logic [6:0]      EX_OPCODE,
    output logic [2:0]      EX_FUNCT3,
    output logic            EX_FUNCT7B5,
    output logic            EX_REGWRITE,
    output logic            EX_MEMREAD,
    output logic            EX_MEMWRITE,
    output logic            EX_ILLEGAL
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] imm;
    logic            legal, uses_rs1, uses_rs2, writes_rd, mem_rd, mem_wr;
    logic [XLEN-1:0] op1, op2;
    logic            hazard, bubble;

    assign opcode = IF_INSTR[6:0];
    assign rd_f   = IF_INSTR[11:7];
    assign RNUM1  = IF_INSTR[19:15];
    assign RNUM2  = IF_INSTR[24:20];

    assign imm_i = {{20{IF_INSTR[31]}}, IF_INSTR[31:20]};
    assign imm_s = {{20{IF_INSTR[31]}}, IF_INSTR[31:25], IF_INSTR[11:7]};
    assign imm_b = {{19{IF_INSTR[31]}}, IF_INSTR[31], IF_INSTR[7], IF_INSTR[30:25],
                    IF_INSTR[11:8], 1'b0};
    assign imm_u = {IF_INSTR[31:12], 12'b0};
    assign imm_j = {{11{IF_INSTR[31]}}, IF_INSTR[31], IF_INSTR[19:12], IF_INSTR[20],
                    IF_INSTR[30:21], 1'b0};

    // Unknown opcodes keep uses_rs1 set so a suspicious encoding still waits on a load.
    always_comb begin
        legal     = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        imm       = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
                imm       = imm_u;
            end
            OPC_JAL: begin
                uses_rs1  = 1'b0;
                writes_rd = 1'b1;
                imm       = imm_j;
            end
            OPC_JALR, OPC_OPIMM: begin
                writes_rd = 1'b1;
                imm       = imm_i;
            end
            OPC_LOAD: begin
                writes_rd = 1'b1;
                mem_rd    = 1'b1;
                imm       = imm_i;
            end
            OPC_STORE: begin
                uses_rs2 = 1'b1;
                mem_wr   = 1'b1;
                imm      = imm_s;
            end
            OPC_BRANCH: begin
                uses_rs2 = 1'b1;
                imm      = imm_b;
            end
            OPC_OP: begin
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                imm = imm_i;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // The register file writes on the same edge we sample, so its read port is stale.
    assign op1 = (WB_WNUM != '0 && WB_WNUM == RNUM1) ? WB_WDATA : RDATA1;
    assign op2 = (WB_WNUM != '0 && WB_WNUM == RNUM2) ? WB_WDATA : RDATA2;

    assign hazard = (uses_rs1 && RNUM1 == EX_RD) || (uses_rs2 && RNUM2 == EX_RD);
    assign STALL  = IF_VALID && EX_VALID && EX_MEMREAD && (EX_RD != '0) && !EX_FLUSH && hazard;
    assign bubble = !IF_VALID || EX_FLUSH || STALL;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            EX_VALID    <= 1'b0;
            EX_PC       <= NOP_PC;
            EX_RS1VAL   <= '0;
            EX_RS2VAL   <= '0;
            EX_IMM      <= '0;
            EX_RS1      <= '0;
            EX_RS2      <= '0;
            EX_RD       <= '0;
            EX_OPCODE   <= '0;
            EX_FUNCT3   <= '0;
            EX_FUNCT7B5 <= 1'b0;
            EX_REGWRITE <= 1'b0;
            EX_MEMREAD  <= 1'b0;
            EX_MEMWRITE <= 1'b0;
            EX_ILLEGAL  <= 1'b0;
        end else if (bubble) begin
            EX_VALID    <= 1'b0;
            EX_PC       <= NOP_PC;
            EX_RS1VAL   <= '0;
            EX_RS2VAL   <= '0;
            EX_IMM      <= '0;
            EX_RS1      <= '0;
            EX_RS2      <= '0;
            EX_RD       <= '0;
            EX_OPCODE   <= '0;
            EX_FUNCT3   <= '0;
            EX_FUNCT7B5 <= 1'b0;
            EX_REGWRITE <= 1'b0;
            EX_MEMREAD  <= 1'b0;
            EX_MEMWRITE <= 1'b0;
            EX_ILLEGAL  <= 1'b0;
        end else begin
            EX_VALID    <= 1'b1;
            EX_PC       <= IF_PC;
            EX_RS1VAL   <= op1;
            EX_RS2VAL   <= op2;
            EX_IMM      <= imm;
            EX_RS1      <= RNUM1;
            EX_RS2      <= RNUM2;
            EX_RD       <= rd_f;
            EX_OPCODE   <= opcode;
            EX_FUNCT3   <= IF_INSTR[14:12];
            EX_FUNCT7B5 <= IF_INSTR[30];
            EX_REGWRITE <= writes_rd && (rd_f != '0);
            EX_MEMREAD  <= mem_rd;
            EX_MEMWRITE <= mem_wr;
            EX_ILLEGAL  <= !legal;
        end
    end

endmodule
